// File: rtl/snake_collision.sv
// Snake collision checker: snapshots the body bus on start, flags wall hits immediately,
// then walks the valid tail segments one per clock looking for a head/segment match.
module snake_collision #(
  parameter int unsigned GRID_W = 64,
  parameter int unsigned GRID_H = 48,
  parameter int unsigned SEG_N  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic [6:0]         head_x,
  input  logic [5:0]         head_y,
  input  logic [SEG_N*7-1:0] tail_x,
  input  logic [SEG_N*6-1:0] tail_y,
  input  logic [3:0]         tail_len,
  output logic               busy,
  output logic               done,
  output logic               hit_self,
  output logic               hit_wall,
  output logic               game_over
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         len_q, len_d;
  logic [6:0]         hx_q, hx_d;
  logic [5:0]         hy_q, hy_d;
  logic [SEG_N*7-1:0] tx_q, tx_d;
  logic [SEG_N*6-1:0] ty_q, ty_d;
  logic               wall_acc_q, wall_acc_d;
  logic               self_acc_q, self_acc_d;
  logic               done_q, done_d;
  logic               hit_self_q, hit_self_d;
  logic               hit_wall_q, hit_wall_d;
  logic               game_over_q, game_over_d;

  logic [6:0] seg_x;
  logic [5:0] seg_y;
  logic [3:0] len_sat;
  logic       head_out;
  logic       finish;

  // Segment currently addressed by the scan index.
  always_comb begin
    seg_x = '0;
    seg_y = '0;
    for (int k = 0; k < SEG_N; k++) begin
      if (idx_q == 4'(k)) begin
        seg_x = tx_q[7*k +: 7];
        seg_y = ty_q[6*k +: 6];
      end
    end
  end

  // Negative coordinates arrive wrapped to large values, so one unsigned compare covers both edges.
  assign head_out = (32'(head_x) >= GRID_W) | (32'(head_y) >= GRID_H);
  assign len_sat  = (32'(tail_len) > SEG_N) ? 4'(SEG_N) : tail_len;
  assign finish   = (state_q == StScan) && (idx_q == len_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    hx_d        = hx_q;
    hy_d        = hy_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    wall_acc_d  = wall_acc_q;
    self_acc_d  = self_acc_q;
    done_d      = done_q;
    hit_self_d  = hit_self_q;
    hit_wall_d  = hit_wall_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          hx_d       = head_x;
          hy_d       = head_y;
          tx_d       = tail_x;
          ty_d       = tail_y;
          len_d      = len_sat;
          idx_d      = '0;
          wall_acc_d = head_out;
          self_acc_d = 1'b0;
          state_d    = StScan;
        end
      end
      StScan: begin
        if (idx_q < len_q) begin
          if ((seg_x == hx_q) && (seg_y == hy_q)) begin
            self_acc_d = 1'b1;
          end
          idx_d = idx_q + 4'd1;
        end else begin
          state_d    = StDone;
          done_d     = 1'b1;
          hit_self_d = self_acc_q;
          hit_wall_d = wall_acc_q;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        done_d  = 1'b0;
      end
    endcase
  end

  // A colliding done outranks a simultaneous clear.
  always_comb begin
    game_over_d = game_over_q;
    if (finish && (self_acc_q || wall_acc_q)) begin
      game_over_d = 1'b1;
    end else if (clear) begin
      game_over_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      len_q       <= '0;
      hx_q        <= '0;
      hy_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      wall_acc_q  <= 1'b0;
      self_acc_q  <= 1'b0;
      done_q      <= 1'b0;
      hit_self_q  <= 1'b0;
      hit_wall_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      hx_q        <= hx_d;
      hy_q        <= hy_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      wall_acc_q  <= wall_acc_d;
      self_acc_q  <= self_acc_d;
      done_q      <= done_d;
      hit_self_q  <= hit_self_d;
      hit_wall_q  <= hit_wall_d;
      game_over_q <= game_over_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign hit_self  = hit_self_q;
  assign hit_wall  = hit_wall_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_collision.sv
// Bench for snake_collision: a countdown-style result model checked every cycle, plus directed
// scenarios with literal latency and flag expectations.
module tb_snake_collision;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [6:0]   head_x = '0;
  logic [5:0]   head_y = '0;
  logic [104:0] tail_x = '0;
  logic [89:0]  tail_y = '0;
  logic [3:0]   tail_len = '0;
  logic         busy, done, hit_self, hit_wall, game_over;

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;

  snake_collision #(
    .GRID_W(64),
    .GRID_H(48),
    .SEG_N (15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .head_x   (head_x),
    .head_y   (head_y),
    .tail_x   (tail_x),
    .tail_y   (tail_y),
    .tail_len (tail_len),
    .busy     (busy),
    .done     (done),
    .hit_self (hit_self),
    .hit_wall (hit_wall),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the whole result is known the moment start is accepted; only its timing is deferred.
  int m_phase = 0;  // 0 idle, 1 scanning, 2 done cycle
  int m_cnt = 0;    // edges left before the done edge
  int m_len = 0;
  bit p_self = 0, p_wall = 0;
  bit e_done = 0, e_self = 0, e_wall = 0, e_go = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_phase = 0; m_cnt = 0; p_self = 0; p_wall = 0;
      e_done = 0; e_self = 0; e_wall = 0; e_go = 0;
    end else begin
      e_done = 0;
      case (m_phase)
        0: if (start) begin
          m_len = int'(tail_len);
          if (m_len > 15) m_len = 15;
          p_wall = (int'(head_x) >= 64) || (int'(head_y) >= 48);
          p_self = 0;
          for (int k = 0; k < m_len; k++)
            if (tail_x[7*k +: 7] == head_x && tail_y[6*k +: 6] == head_y) p_self = 1;
          m_cnt = m_len;
          m_phase = 1;
        end
        1: if (m_cnt == 0) begin
          e_done = 1; e_self = p_self; e_wall = p_wall; m_phase = 2;
        end else m_cnt--;
        default: m_phase = 0;
      endcase
      if (e_done && (p_self || p_wall)) e_go = 1;
      else if (clear) e_go = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    check("busy", int'(busy), int'(m_phase != 0));
    check("done", int'(done), int'(e_done));
    check("hit_self", int'(hit_self), int'(e_self));
    check("hit_wall", int'(hit_wall), int'(e_wall));
    check("game_over", int'(game_over), int'(e_go));
  end

  task automatic set_seg(input int k, input int x, input int y);
    tail_x[7*k +: 7] = 7'(x);
    tail_y[6*k +: 6] = 6'(y);
  endtask

  task automatic fill_tail();
    for (int k = 0; k < 15; k++) set_seg(k, k + 1, 1);
  endtask

  // Pulse start on the next edge N; lat = edges after N until done is seen.
  task automatic run(input int len, input int hx, input int hy, output int lat);
    head_x = 7'(hx); head_y = 6'(hy); tail_len = 4'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("done_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int lat;
  int pre;

  initial begin
    #1 reset = 1'b0;
    fill_tail();
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_hit_self", int'(hit_self), 0);
    check("rst_hit_wall", int'(hit_wall), 0);
    check("rst_game_over", int'(game_over), 0);
    #2 reset = 1'b1;
    @(negedge clk);

    // 1: empty tail, head mid-grid
    run(0, 32, 24, lat);
    check("t1_lat", lat, 1);
    check("t1_self", int'(hit_self), 0);
    check("t1_wall", int'(hit_wall), 0);
    check("t1_go", int'(game_over), 0);
    @(negedge clk);

    // 2: newest-but-two segment overlaps head
    set_seg(0, 31, 24); set_seg(1, 30, 24); set_seg(2, 32, 24);
    run(3, 32, 24, lat);
    check("t2_lat", lat, 4);
    check("t2_self", int'(hit_self), 1);
    check("t2_wall", int'(hit_wall), 0);
    check("t2_go", int'(game_over), 1);
    @(negedge clk);
    fill_tail();

    // 3: wall boundaries
    run(0, 127, 24, lat);
    check("t3_underflow_wall", int'(hit_wall), 1);
    @(negedge clk);
    run(0, 10, 48, lat);
    check("t3_bottom_wall", int'(hit_wall), 1);
    @(negedge clk);
    run(0, 63, 47, lat);
    check("t3_corner_wall", int'(hit_wall), 0);
    check("t3_corner_self", int'(hit_self), 0);
    @(negedge clk);

    // 4: match beyond tail_len is ignored; match in last segment found
    set_seg(5, 32, 24);
    run(3, 32, 24, lat);
    check("t4_short_self", int'(hit_self), 0);
    @(negedge clk);
    set_seg(14, 32, 24);
    run(15, 32, 24, lat);
    check("t4_full_lat", lat, 16);
    check("t4_full_self", int'(hit_self), 1);
    @(negedge clk);
    fill_tail();

    // 5: restart and head change during scan must not disturb the snapshot
    pre = done_cnt;
    head_x = 7'd32; head_y = 6'd24; tail_len = 4'd3;
    start = 1'b1;
    @(negedge clk);
    head_x = 7'd1; head_y = 6'd1;  // now equals segment 0
    lat = 0;
    @(negedge clk); lat++;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t5_lat", lat, 4);
    check("t5_self", int'(hit_self), 0);
    check("t5_wall", int'(hit_wall), 0);
    head_x = 7'd32; head_y = 6'd24;
    repeat (3) @(negedge clk);
    check("t5_one_done", done_cnt - pre, 1);

    // 6: reset aborts a colliding scan
    set_seg(9, 32, 24);
    head_x = 7'd32; head_y = 6'd24; tail_len = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pre = done_cnt;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("t6_abort_busy", int'(busy), 0);
    check("t6_abort_done", int'(done), 0);
    check("t6_abort_go", int'(game_over), 0);
    repeat (3) @(negedge clk);
    check("t6_no_done", done_cnt - pre, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    fill_tail();

    // clear on the same edge as a colliding done: set wins; clear alone then drops it
    head_x = 7'd127; head_y = 6'd0; tail_len = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    check("t6_clr_done", int'(done), 1);
    check("t6_clr_set_wins", int'(game_over), 1);
    @(negedge clk);
    check("t6_clr_alone", int'(game_over), 0);
    clear = 1'b0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
